uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single `corescore_emitter_uart` between the two torv32 harts (A and B) of the dual-issue SOC build. Each hart's UART IO writes go into a private byte FIFO, and a round-robin arbiter drains the FIFOs into the emitter's valid/ready port. Optional line locking keeps one hart's line contiguous on the console. The block sits between the per-hart `*_uart_valid` / `*_IO_mem_wdata[7:0]` decode and the emitter's `i_valid` / `i_data` / `o_ready`.

## Interface
- `DEPTH`, 4: entries per hart FIFO; power of two, at least 2.
- `LINE_LOCK`, 1: when 1, the grant is held until the owner sends 0x0A or times out; when 0, the grant is released after every byte.
- `LOCK_TIMEOUT`, 255: idle cycles in HOLD before a locked grant is released; range 1..65535.

Ports:
- `clk`  in  1  system clock; the single clock of the block.
- `reset`  in  1  asynchronous, active-high reset.
- `a_wr`  in  1  hart A write strobe.
- `a_data`  in  8  hart A byte.
- `a_full`  out  1  hart A FIFO full; feeds hart A's UART status read bit.
- `b_wr`  in  1  hart B write strobe.
- `b_data`  in  8  hart B byte.
- `b_full`  out  1  hart B FIFO full.
- `uart_valid`  out  1  to emitter `i_valid`.
- `uart_data`  out  8  to emitter `i_data`.
- `uart_ready`  in  1  from emitter `o_ready`.
- `grant`  out  1  current or last owner; 0 = A, 1 = B.

## Operation
- **FIFOs.** One FIFO per hart, each holding DEPTH entries.
  - A push happens at the clock edge when `x_wr` is high and `x_full` is low.
  - A write while `x_full` is high is dropped silently, even if a pop occurs in the same cycle.
  - `x_full` is asserted when count == DEPTH and is derived from registered state only.
  - Read and write pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle leave the count unchanged.
- **FSM states.** IDLE, SEND, HOLD. A 1-bit `last` register records which hart was served most recently.
- **IDLE**
  - If only one FIFO is non-empty, that hart becomes the owner.
  - If both are non-empty, the owner is the hart not equal to `last`.
  - On selecting an owner: pop the owner's head into the `uart_data` register, set `grant` to the owner, and go to SEND.
  - If both FIFOs are empty, remain in IDLE.
- **SEND**
  - `uart_valid` = 1.
  - `uart_data` is held stable until the handshake (`uart_valid` and `uart_ready` both high at an edge).
  - On handshake, the sent byte is S:
    - LINE_LOCK = 0, or S == 0x0A: set `last` to the owner and go to IDLE.
    - Otherwise, if the owner FIFO is non-empty: pop its head into `uart_data` and remain in SEND (back-to-back).
    - Otherwise: go to HOLD and clear the timeout counter.
- **HOLD**
  - `uart_valid` = 0.
  - If the owner FIFO is non-empty: pop its head into `uart_data`, go to SEND, and clear the counter.
  - Otherwise the counter increments each cycle. When it reaches LOCK_TIMEOUT, set `last` to the owner and go to IDLE.
  - The other hart's FIFO is not serviced while in HOLD.
- **Counter width.** The counter is 16 bits and saturates at LOCK_TIMEOUT.
- **Bytes are opaque.** No byte value other than 0x0A is interpreted.
- **Per-hart ordering.** Bytes from one hart reach the emitter in push order, with no loss except writes dropped while full.

## Timing
- **Reset values.** All of the following take effect asynchronously on `reset` = 1:
  - `uart_valid` = 0, `uart_data` = 0x00, `grant` = 0.
  - `a_full` = 0, `b_full` = 0, FIFOs empty.
  - State IDLE, `last` = 1 (so A wins the first tie), counter = 0.
- **Reset mid-operation.** `uart_valid` drops immediately and any byte in flight or queued is lost. The emitter is reset by the same source.
- **Write-to-valid latency.** A byte pushed at edge k into an empty block in IDLE gives `uart_valid` = 1 after edge k+1.
- **Same-edge push and pop.** A push and a pop of the same FIFO at the same edge are both honoured.
- **Throughput.**
  - Back-to-back same-owner bytes in SEND: the next byte is presented the cycle after the handshake.
  - Release to IDLE costs one bubble cycle before the next grant.
- **Emitter handshake.** `uart_valid` never falls without a handshake, except on reset. `uart_data` changes only on the load edge.
- **Simultaneous first writes.** If both harts write in the same cycle while IDLE, A is served first after reset; afterwards the tie goes to the hart not in `last`.
- **Full flag timing.** A FIFO at DEPTH that pops at edge k deasserts `x_full` after edge k. A write presented in the same cycle as that pop is still dropped.

## Test plan
- **Reset behaviour:** assert `reset` mid-SEND with `uart_valid` = 1 -> `uart_valid`, `grant`, `a_full`, `b_full` all 0 with no clock edge; FIFOs empty after release.
- **Single hart, LINE_LOCK = 0:** A writes 'H' (0x48) at edge 0, with `uart_ready` pulsed 3 cycles later -> `uart_valid` = 1 after edge 1, `uart_data` = 0x48 held until the handshake, then IDLE.
- **Tie and round-robin, LINE_LOCK = 0:** A and B each write 2 bytes in the same cycle, ready always high -> emitter order A0, B0, A1, B1.
- **Line lock, LINE_LOCK = 1:** A writes "ab\n" and B writes "xy\n" in the same cycles -> emitter order a, b, 0x0A, x, y, 0x0A.
- **Lock timeout, LINE_LOCK = 1, LOCK_TIMEOUT = 8:** A sends 'a' (no newline) while B has 'x' queued -> HOLD for 8 cycles, then B granted and 'x' sent.
- **Overflow, DEPTH = 4:** `uart_ready` = 0 and A writes 6 bytes 0x01..0x06 -> the first is loaded to `uart_data`, the FIFO fills with 0x02..0x05, `a_full` = 1, and 0x06 is dropped. When ready rises: output 0x01..0x05 in order.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter draining two per-hart byte FIFOs into one UART emitter
module uart_tx_arbiter #(
    parameter int DEPTH        = 4,
    parameter int LINE_LOCK    = 1,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_wr,
    input  logic [7:0] a_data,
    output logic       a_full,
    input  logic       b_wr,
    input  logic [7:0] b_data,
    output logic       b_full,
    output logic       uart_valid,
    output logic [7:0] uart_data,
    input  logic       uart_ready,
    output logic       grant
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    state_t        state;
    logic          last;
    logic [15:0]   cnt;
    logic [7:0]    a_mem [DEPTH];
    logic [7:0]    b_mem [DEPTH];
    logic [AW-1:0] a_rd, a_wp, b_rd, b_wp;
    logic [AW:0]   a_cnt, b_cnt;
    logic          a_ne, b_ne, sel_b, own_ne, rel, pop_own;
    logic          a_pop, b_pop, a_push, b_push;
    logic [7:0]    own_head, sel_head;

    assign a_full = a_cnt == FULL;
    assign b_full = b_cnt == FULL;

    // Owner selection and pop/push decisions shared by the FIFOs and the FSM
    always_comb begin
        a_ne     = |a_cnt;
        b_ne     = |b_cnt;
        sel_b    = b_ne && (!a_ne || !last);
        own_ne   = grant ? b_ne : a_ne;
        own_head = grant ? b_mem[b_rd] : a_mem[a_rd];
        sel_head = sel_b ? b_mem[b_rd] : a_mem[a_rd];
        rel      = LINE_LOCK == 0 || uart_data == 8'h0A;
        pop_own  = own_ne && ((state == SEND && uart_ready && !rel) || state == HOLD);
        a_pop    = (state == IDLE && a_ne && !sel_b) || (pop_own && !grant);
        b_pop    = (state == IDLE && sel_b) || (pop_own && grant);
        a_push   = a_wr && !a_full;
        b_push   = b_wr && !b_full;
    end

    // FIFO storage; pointers alone define occupancy so the array needs no reset
    always_ff @(posedge clk) begin
        if (a_push) a_mem[a_wp] <= a_data;
        if (b_push) b_mem[b_wp] <= b_data;
    end

    // FIFO pointers and counts; full is judged before any same-edge pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rd  <= '0;
            a_wp  <= '0;
            a_cnt <= '0;
            b_rd  <= '0;
            b_wp  <= '0;
            b_cnt <= '0;
        end else begin
            a_rd  <= a_rd + AW'(a_pop);
            a_wp  <= a_wp + AW'(a_push);
            a_cnt <= a_cnt + (AW+1)'(a_push) - (AW+1)'(a_pop);
            b_rd  <= b_rd + AW'(b_pop);
            b_wp  <= b_wp + AW'(b_push);
            b_cnt <= b_cnt + (AW+1)'(b_push) - (AW+1)'(b_pop);
        end
    end

    // Arbitration FSM with registered emitter outputs and line-lock timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last       <= 1'b1;
            cnt        <= '0;
            grant      <= 1'b0;
            uart_valid <= 1'b0;
            uart_data  <= 8'h00;
        end else begin
            case (state)
                IDLE: if (a_ne || b_ne) begin
                    grant      <= sel_b;
                    uart_data  <= sel_head;
                    uart_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: if (uart_ready) begin
                    if (rel) begin
                        last       <= grant;
                        uart_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (own_ne) begin
                        uart_data <= own_head;
                    end else begin
                        uart_valid <= 1'b0;
                        cnt        <= '0;
                        state      <= HOLD;
                    end
                end
                HOLD: if (own_ne) begin
                    uart_data  <= own_head;
                    uart_valid <= 1'b1;
                    cnt        <= '0;
                    state      <= SEND;
                end else begin
                    cnt <= (cnt == 16'(LOCK_TIMEOUT)) ? cnt : cnt + 16'd1;
                    if (cnt == 16'(LOCK_TIMEOUT - 1)) begin
                        last  <= grant;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of an unlocked and a line-locked arbiter instance
module tb_uart_tx_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_wr = 1'b0, b_wr = 1'b0, uart_ready = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_full0, b_full0, valid0, grant0, a_full1, b_full1, valid1, grant1;
    logic [7:0] data0, data1;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         errors = 0;
    int         checks = 0;

    uart_tx_arbiter #(.DEPTH(4), .LINE_LOCK(0), .LOCK_TIMEOUT(255)) u0 (
        .clk(clk), .reset(reset),
        .a_wr(a_wr), .a_data(a_data), .a_full(a_full0),
        .b_wr(b_wr), .b_data(b_data), .b_full(b_full0),
        .uart_valid(valid0), .uart_data(data0), .uart_ready(uart_ready), .grant(grant0)
    );

    uart_tx_arbiter #(.DEPTH(4), .LINE_LOCK(1), .LOCK_TIMEOUT(8)) u1 (
        .clk(clk), .reset(reset),
        .a_wr(a_wr), .a_data(a_data), .a_full(a_full1),
        .b_wr(b_wr), .b_data(b_data), .b_full(b_full1),
        .uart_valid(valid1), .uart_data(data1), .uart_ready(uart_ready), .grant(grant1)
    );

    always #5 clk = ~clk;

    // Record every byte the emitter accepts; inputs only change just after posedge
    always @(negedge clk) begin
        if (!reset && valid0 && uart_ready) q0.push_back(data0);
        if (!reset && valid1 && uart_ready) q1.push_back(data1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        a_wr = 1'b0;
        b_wr = 1'b0;
        uart_ready = 1'b0;
        #1 reset = 1'b0;
    endtask

    initial begin
        int base;
        logic [7:0] e3 [4];
        logic [7:0] e4 [6];
        e3 = '{8'h10, 8'h20, 8'h11, 8'h21};
        e4 = '{8'h61, 8'h62, 8'h0A, 8'h78, 8'h79, 8'h0A};

        #1;
        check("rst valid", valid0, 0);
        check("rst data", data0, 0);
        check("rst grant", grant0, 0);
        check("rst a_full", a_full0, 0);
        check("rst b_full", b_full0, 0);
        #2 reset = 1'b0;

        // single hart, unlocked: latency and hold until handshake
        do_reset();
        base = q0.size();
        a_wr = 1'b1;
        a_data = 8'h48;
        step();
        a_wr = 1'b0;
        check("single valid e0", valid0, 0);
        step();
        check("single valid e1", valid0, 1);
        check("single data e1", data0, 8'h48);
        check("single grant e1", grant0, 0);
        step();
        check("single valid e2", valid0, 1);
        check("single data e2", data0, 8'h48);
        uart_ready = 1'b1;
        step();
        uart_ready = 1'b0;
        check("single valid after hs", valid0, 0);
        check("single count", q0.size() - base, 1);
        check("single byte", q0[base], 8'h48);

        // tie and round robin, unlocked
        do_reset();
        base = q0.size();
        uart_ready = 1'b1;
        a_wr = 1'b1; b_wr = 1'b1; a_data = 8'h10; b_data = 8'h20;
        step();
        a_data = 8'h11; b_data = 8'h21;
        step();
        a_wr = 1'b0; b_wr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("rr count", q0.size() - base, 4);
        for (int i = 0; i < 4; i++) check($sformatf("rr byte%0d", i), q0[base+i], e3[i]);

        // line lock keeps each line contiguous
        do_reset();
        base = q1.size();
        uart_ready = 1'b1;
        a_wr = 1'b1; b_wr = 1'b1; a_data = 8'h61; b_data = 8'h78;
        step();
        a_data = 8'h62; b_data = 8'h79;
        step();
        a_data = 8'h0A; b_data = 8'h0A;
        step();
        a_wr = 1'b0; b_wr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("lock count", q1.size() - base, 6);
        for (int i = 0; i < 6; i++) check($sformatf("lock byte%0d", i), q1[base+i], e4[i]);

        // lock timeout of 8 idle cycles, then B is granted
        do_reset();
        base = q1.size();
        uart_ready = 1'b1;
        a_wr = 1'b1; b_wr = 1'b1; a_data = 8'h61; b_data = 8'h78;
        step();
        a_wr = 1'b0; b_wr = 1'b0;
        step();
        check("to valid e1", valid1, 1);
        check("to data e1", data1, 8'h61);
        step();
        check("to valid hold", valid1, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("to hold%0d valid", i), valid1, 0);
            check($sformatf("to hold%0d grant", i), grant1, 0);
        end
        step();
        check("to b valid", valid1, 1);
        check("to b data", data1, 8'h78);
        check("to b grant", grant1, 1);
        step();
        check("to count", q1.size() - base, 2);
        check("to byte0", q1[base], 8'h61);
        check("to byte1", q1[base+1], 8'h78);

        // overflow: sixth write dropped while full
        do_reset();
        base = q0.size();
        for (int i = 1; i <= 6; i++) begin
            a_wr = 1'b1;
            a_data = 8'(i);
            step();
        end
        a_wr = 1'b0;
        check("ovf a_full", a_full0, 1);
        check("ovf valid", valid0, 1);
        check("ovf data", data0, 8'h01);
        uart_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("ovf count", q0.size() - base, 5);
        for (int i = 0; i < 5; i++) check($sformatf("ovf byte%0d", i), q0[base+i], 8'(i + 1));
        check("ovf a_full end", a_full0, 0);

        // asynchronous reset in the middle of SEND with B full
        do_reset();
        for (int i = 0; i < 5; i++) begin
            b_wr = 1'b1;
            b_data = 8'(8'h31 + i);
            step();
        end
        b_wr = 1'b0;
        check("mid b_full", b_full0, 1);
        check("mid valid", valid0, 1);
        check("mid grant", grant0, 1);
        check("mid data", data0, 8'h31);
        #2 reset = 1'b1;
        #1;
        check("async valid", valid0, 0);
        check("async grant", grant0, 0);
        check("async data", data0, 0);
        check("async b_full", b_full0, 0);
        reset = 1'b0;
        base = q0.size();
        uart_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("post-reset empty", q0.size() - base, 0);
        check("post-reset valid", valid0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
